goboard_info_writer: RTL and testbench

- Character-stream front end for the 16x32 goboard info text RAM. Drives the RAM write port (port A, system clock domain); the VGA text reader consumes the same RAM on port B.
- Accepts one byte per valid/ready handshake from the host/PS-side logic, maintains a text cursor, and interprets a small set of control codes.
- Generates all RAM write traffic: character writes, line clears and page clears.
- RAM address layout is fixed: addr = row*16 + col, i.e. {row[4:0], col[3:0]}.

---
 rtl/goboard_info_writer.sv | 116 +++++++++++
 tb/tb_goboard_info_writer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/goboard_info_writer.sv
// Character-stream front end for the 16x32 goboard info text RAM: accepts bytes,
// tracks a text cursor and generates every write on RAM port A (chars, line and page clears).
module goboard_info_writer #(
    parameter logic [7:0] FILL_CHAR      = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       sys_clk_in,
    input  logic       clr_n,
    input  logic [7:0] char_in,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       wea,
    output logic [8:0] write_ram_addr,
    output logic [7:0] in_char,
    output logic [4:0] cur_row,
    output logic [3:0] cur_col,
    output logic       busy
);

    // Handshake: a byte transfers on every rising edge where char_valid and
    // char_ready are both high; char_in must stay stable until that edge.
    typedef enum logic [1:0] {IDLE, LINE_CLR, PAGE_CLR} state_t;

    state_t     state;
    logic [8:0] cnt;
    logic       printable;

    assign char_ready = (state == IDLE);
    assign printable  = (char_in >= 8'h20) && (char_in <= 8'h7E);

    always_ff @(posedge sys_clk_in or negedge clr_n) begin
        if (!clr_n) begin
            state          <= CLEAR_ON_RESET ? PAGE_CLR : IDLE;
            busy           <= CLEAR_ON_RESET;
            cnt            <= 9'd0;
            wea            <= 1'b0;
            write_ram_addr <= 9'd0;
            in_char        <= FILL_CHAR;
            cur_row        <= 5'd0;
            cur_col        <= 4'd0;
        end else begin
            wea <= 1'b0;
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        if (printable) begin
                            wea            <= 1'b1;
                            write_ram_addr <= {cur_row, cur_col};
                            in_char        <= char_in;
                            cur_col        <= cur_col + 4'd1;
                            // Wrapping off the last column opens a fresh, cleared line.
                            if (cur_col == 4'd15) begin
                                cur_row <= cur_row + 5'd1;
                                cnt     <= 9'd0;
                                state   <= LINE_CLR;
                                busy    <= 1'b1;
                            end
                        end else begin
                            case (char_in)
                                8'h0A: begin
                                    cur_col <= 4'd0;
                                    cur_row <= cur_row + 5'd1;
                                    cnt     <= 9'd0;
                                    state   <= LINE_CLR;
                                    busy    <= 1'b1;
                                end
                                8'h0D: cur_col <= 4'd0;
                                8'h08: begin
                                    if (cur_col != 4'd0) begin
                                        cur_col        <= cur_col - 4'd1;
                                        wea            <= 1'b1;
                                        write_ram_addr <= {cur_row, cur_col - 4'd1};
                                        in_char        <= FILL_CHAR;
                                    end
                                end
                                8'h0C: begin
                                    cur_row <= 5'd0;
                                    cur_col <= 4'd0;
                                    cnt     <= 9'd0;
                                    state   <= PAGE_CLR;
                                    busy    <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                LINE_CLR: begin
                    wea            <= 1'b1;
                    write_ram_addr <= {cur_row, cnt[3:0]};
                    in_char        <= FILL_CHAR;
                    cnt            <= cnt + 9'd1;
                    if (cnt[3:0] == 4'd15) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                PAGE_CLR: begin
                    wea            <= 1'b1;
                    write_ram_addr <= cnt;
                    in_char        <= FILL_CHAR;
                    cnt            <= cnt + 9'd1;
                    if (cnt == 9'd511) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goboard_info_writer.sv
// Randomized bench for goboard_info_writer: a cursor/text model predicts every RAM
// write into an ordered queue that the write monitor drains.
module tb_goboard_info_writer;

    logic       clk;
    logic       clr_n;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic       wea;
    logic [8:0] write_ram_addr;
    logic [7:0] in_char;
    logic [4:0] cur_row;
    logic [3:0] cur_col;
    logic       busy;

    goboard_info_writer #(.FILL_CHAR(8'h20), .CLEAR_ON_RESET(1'b1)) dut (
        .sys_clk_in     (clk),
        .clr_n          (clr_n),
        .char_in        (char_in),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .wea            (wea),
        .write_ram_addr (write_ram_addr),
        .in_char        (in_char),
        .cur_row        (cur_row),
        .cur_col        (cur_col),
        .busy           (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: text cursor plus ordered list of expected {addr, data} writes
    logic [16:0] exp_q[$];
    int m_row, m_col;

    task automatic push_wr(input int addr, input int data);
        exp_q.push_back({addr[8:0], data[7:0]});
    endtask

    task automatic push_line_clear(input int row);
        for (int c = 0; c < 16; c++) push_wr(row * 16 + c, 32);
    endtask

    task automatic push_page_clear();
        for (int a = 0; a < 512; a++) push_wr(a, 32);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        push_page_clear();
    endtask

    task automatic model_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(m_row * 16 + m_col, b);
            m_col++;
            if (m_col == 16) begin
                m_col = 0;
                m_row = (m_row + 1) % 32;
                push_line_clear(m_row);
            end
        end else if (b == 8'h0A) begin
            m_col = 0;
            m_row = (m_row + 1) % 32;
            push_line_clear(m_row);
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row * 16 + m_col, 32);
            end
        end else if (b == 8'h0C) begin
            m_row = 0;
            m_col = 0;
            push_page_clear();
        end
    endtask

    // scoreboard: every observed write must be the next expected one
    int cyc = 0;
    int wr_cyc_last = 0;
    int wr_cyc_prev = 0;

    always @(negedge clk) begin
        cyc++;
        if (clr_n) begin
            check("ready_vs_busy", {31'd0, char_ready}, {31'd0, !busy});
            if (wea) begin
                wr_cyc_prev = wr_cyc_last;
                wr_cyc_last = cyc;
                if (exp_q.size() == 0) check("unexpected_write", {15'd0, write_ram_addr, in_char}, 32'hFFFF_FFFF);
                else check("ram_write", {15'd0, write_ram_addr, in_char}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    // drivers
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        char_in    = b;
        char_valid = 1'b1;
        while (!char_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check("accept_timeout", 32'd1, 32'd0);
        model_apply(b);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_in    = 8'h00;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (!char_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check({tag, "_idle_timeout"}, 32'd1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        check({tag, "_row"}, {27'd0, cur_row}, m_row);
        check({tag, "_col"}, {28'd0, cur_col}, m_col);
    endtask

    task automatic goto_pos(input int row, input int col);
        send_byte(8'h0C);
        for (int r = 0; r < row; r++) send_byte(8'h0A);
        for (int c = 0; c < col; c++) send_byte(8'($urandom_range(32, 126)));
        wait_idle("goto");
    endtask

    int n;
    logic [7:0] rb;

    initial begin
        clr_n      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        m_row      = 0;
        m_col      = 0;
        repeat (3) @(negedge clk);
        check("rst_wea", {31'd0, wea}, 32'd0);
        check("rst_addr", {23'd0, write_ram_addr}, 32'd0);
        check("rst_data", {24'd0, in_char}, 32'h20);
        check("rst_cursor", {23'd0, cur_row, cur_col}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);
        check("rst_ready", {31'd0, char_ready}, 32'd0);

        // power-up page clear: 512 busy cycles
        model_reset();
        clr_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!char_ready && n < 2000);
        check("page_clr_cycles", n, 32'd512);
        wait_idle("after_reset");

        // back-to-back printable bytes
        send_byte(8'h41);
        send_byte(8'h42);
        wait_idle("ab");
        check("ab_consecutive", wr_cyc_last - wr_cyc_prev, 32'd1);
        check("ab_col", {28'd0, cur_col}, 32'd2);

        // wrap at column 15 into a line clear
        goto_pos(3, 15);
        send_byte(8'h5A);
        n = 0;
        @(negedge clk);
        while (!char_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("wrap_ready_low_cycles", n, 32'd16);
        wait_idle("wrap");

        // LF from the last row wraps to row 0
        goto_pos(31, 7);
        send_byte(8'h0A);
        wait_idle("lf_wrap");

        // CR
        goto_pos(5, 9);
        send_byte(8'h0D);
        wait_idle("cr");

        // backspace at column 0, then mid-line, then a dropped control byte
        goto_pos(2, 0);
        send_byte(8'h08);
        wait_idle("bs_col0");
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(32, 126)));
        send_byte(8'h08);
        send_byte(8'h07);
        wait_idle("bs_mid");

        // randomized mix
        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 65) rb = 8'($urandom_range(32, 126));
            else if (n < 75) rb = 8'h0A;
            else if (n < 80) rb = 8'h0D;
            else if (n < 90) rb = 8'h08;
            else if (n < 91) rb = 8'h0C;
            else rb = 8'($urandom_range(0, 255));
            send_byte(rb);
        end
        wait_idle("random");

        // reset in the middle of a page clear
        send_byte(8'h0C);
        n = 0;
        while (exp_q.size() > 412 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) check("mid_clear_timeout", 32'd1, 32'd0);
        #3;
        clr_n = 1'b0;
        #1;
        check("abort_wea", {31'd0, wea}, 32'd0);
        check("abort_addr", {23'd0, write_ram_addr}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        wait_idle("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
